// File: rtl/led_pkg.sv
// -----------------------------------------------------------------------------
// led_pkg
// Shared encodings for the LED pattern engine.
//   mode_e : run-time pattern mode as presented on the 2-bit mode switches.
//   DIR_*  : direction values, used both for the dir switch and for the
//            internal bounce direction.
// -----------------------------------------------------------------------------
package led_pkg;

  typedef enum logic [1:0] {
    MODE_ROTATE = 2'd0,
    MODE_FLASH  = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_COUNT  = 2'd3
  } mode_e;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/led_pattern_engine_sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Parametrised-width two-flop synchroniser for asynchronous switch inputs.
// Ports:
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, both stages clear to 0
//   d     : asynchronous input bus (W bits)
//   q     : synchronised output bus (W bits), two clocks behind d
// -----------------------------------------------------------------------------
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/led_pattern_engine.sv
// -----------------------------------------------------------------------------
// led_pattern_engine
// Switch-driven LED pattern generator: step-rate divider plus four patterns
// (rotate, flash, bounce, binary count) with direction control and pause.
// Ports:
//   CLK_5_MHZ  : system clock
//   CPU_RESETN : asynchronous active-low reset
//   mode       : async mode switches (0 rotate, 1 flash, 2 bounce, 3 count)
//   dir        : async direction switch (0 left/up, 1 right/down)
//   pause      : async pause switch (1 freezes the pattern)
//   led        : registered LED pattern
//   step_tick  : one-cycle pulse coincident with every pattern advance
//   mode_q     : currently active (synchronised) mode
// -----------------------------------------------------------------------------
module led_pattern_engine
  import led_pkg::*;
#(
  parameter int LED_W   = 16,
  parameter int CLK_HZ  = 5000000,
  parameter int STEP_HZ = 2
) (
  input  logic             CLK_5_MHZ,
  input  logic             CPU_RESETN,
  input  logic [1:0]       mode,
  input  logic             dir,
  input  logic             pause,
  output logic [LED_W-1:0] led,
  output logic             step_tick,
  output logic [1:0]       mode_q
);

  localparam int DIV   = CLK_HZ / STEP_HZ;
  localparam int CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

  // Synchronised switch values; nothing below looks at the raw inputs.
  logic [1:0] mode_s;
  logic       dir_s;
  logic       pause_s;

  sync_2ff #(.W(4)) u_sync (
    .clk   (CLK_5_MHZ),
    .rst_n (CPU_RESETN),
    .d     ({mode, dir, pause}),
    .q     ({mode_s, dir_s, pause_s})
  );

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [LED_W-1:0] led_q, led_d;
  logic [1:0]       mode_d;
  logic             bdir_q, bdir_d;
  logic             step_tick_q, step_tick_d;
  logic             tick;
  logic             mode_chg;

  assign tick     = (cnt_q == CNT_MAX) && !pause_s;
  assign mode_chg = (mode_s != mode_q);

  always_comb begin
    cnt_d       = cnt_q;
    led_d       = led_q;
    mode_d      = mode_q;
    bdir_d      = bdir_q;
    step_tick_d = 1'b0;

    if (mode_chg) begin
      // A mode change wins over a coincident tick and also applies while
      // paused: reload the pattern and restart the step period.
      mode_d = mode_s;
      cnt_d  = '0;
      bdir_d = DIR_UP;
      if (mode_s == MODE_ROTATE || mode_s == MODE_BOUNCE) begin
        led_d = LED_W'(1);
      end else begin
        led_d = '0;
      end
    end else if (!pause_s) begin
      cnt_d       = (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_W'(1);
      step_tick_d = tick;
      if (tick) begin
        case (mode_q)
          MODE_ROTATE: begin
            if (dir_s == DIR_UP) begin
              led_d = {led_q[LED_W-2:0], led_q[LED_W-1]};
            end else begin
              led_d = {led_q[0], led_q[LED_W-1:1]};
            end
          end
          MODE_FLASH: led_d = ~led_q;
          MODE_BOUNCE: begin
            // Reverse at the end bit and take the first step back in the
            // same tick, so each end LED is lit for one step only.
            if (bdir_q == DIR_UP) begin
              if (led_q[LED_W-1]) begin
                bdir_d = DIR_DOWN;
                led_d  = led_q >> 1;
              end else begin
                led_d  = led_q << 1;
              end
            end else begin
              if (led_q[0]) begin
                bdir_d = DIR_UP;
                led_d  = led_q << 1;
              end else begin
                led_d  = led_q >> 1;
              end
            end
          end
          default: begin
            if (dir_s == DIR_UP) begin
              led_d = led_q + LED_W'(1);
            end else begin
              led_d = led_q - LED_W'(1);
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge CLK_5_MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      cnt_q       <= '0;
      led_q       <= LED_W'(1);
      mode_q      <= MODE_ROTATE;
      bdir_q      <= DIR_UP;
      step_tick_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      led_q       <= led_d;
      mode_q      <= mode_d;
      bdir_q      <= bdir_d;
      step_tick_q <= step_tick_d;
    end
  end

  assign led       = led_q;
  assign step_tick = step_tick_q;

endmodule

// File: tb/tb_led_pattern_engine.sv
// -----------------------------------------------------------------------------
// tb_led_pattern_engine
// Directed scenarios followed by randomised switch activity on a small
// configuration (4 LEDs, one step every 10 clocks). Expected values come from
// a reference model that tracks each pattern abstractly: a rotate position,
// a flash on/off flag, a ping-pong position and a counter value, plus the
// number of unpaused cycles since the last step.
// -----------------------------------------------------------------------------
module tb_led_pattern_engine;

  localparam int W   = 4;
  localparam int DIV = 10;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [1:0]   mode = 2'd0;
  logic         dir = 1'b0;
  logic         pause = 1'b0;
  logic [W-1:0] led;
  logic         step_tick;
  logic [1:0]   mode_q_o;

  always #5 clk = ~clk;

  led_pattern_engine #(
    .LED_W   (W),
    .CLK_HZ  (10),
    .STEP_HZ (1)
  ) dut (
    .CLK_5_MHZ  (clk),
    .CPU_RESETN (rst_n),
    .mode       (mode),
    .dir        (dir),
    .pause      (pause),
    .led        (led),
    .step_tick  (step_tick),
    .mode_q     (mode_q_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int   m_mode, phase, rot_pos, bpos, cval;
  bit   fl_on, m_tick;
  logic [3:0] s1, s2;   // {mode, dir, pause} as seen one and two edges ago

  always @(posedge clk or negedge rst_n) begin
    int  ms;
    bit  ds, ps;
    if (!rst_n) begin
      m_mode = 0; phase = 0; rot_pos = 0; bpos = 0; cval = 0;
      fl_on = 0; m_tick = 0; s1 = '0; s2 = '0;
    end else begin
      ms = int'(s2[3:2]);
      ds = s2[1];
      ps = s2[0];
      m_tick = 0;
      if (ms != m_mode) begin
        m_mode = ms; phase = 0; rot_pos = 0; bpos = 0; cval = 0; fl_on = 0;
      end else if (!ps) begin
        phase++;
        if (phase == DIV) begin
          phase  = 0;
          m_tick = 1;
          case (m_mode)
            0: rot_pos = ds ? (rot_pos + W - 1) % W : (rot_pos + 1) % W;
            1: fl_on = !fl_on;
            2: bpos = (bpos + 1) % (2 * W - 2);
            default: cval = ds ? (cval + (1 << W) - 1) % (1 << W) : (cval + 1) % (1 << W);
          endcase
        end
      end
      s2 = s1;
      s1 = {mode, dir, pause};
    end
  end

  function automatic logic [W-1:0] exp_led();
    case (m_mode)
      0: return W'(1 << rot_pos);
      1: return fl_on ? {W{1'b1}} : '0;
      2: return W'(1 << ((bpos < W) ? bpos : (2 * W - 2 - bpos)));
      default: return W'(cval);
    endcase
  endfunction

  // Compare every cycle on the falling edge, away from the update edge.
  always @(negedge clk) begin
    if (rst_n) begin
      check("led", 32'(led), 32'(exp_led()));
      check("step_tick", 32'(step_tick), 32'(m_tick));
      check("mode_q", 32'(mode_q_o), 32'(m_mode));
    end
  end

  task automatic async_reset_pulse();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_led", 32'(led), 32'h1);
    check("rst_tick", 32'(step_tick), 32'h0);
    check("rst_mode", 32'(mode_q_o), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("por_led", 32'(led), 32'h1);
    check("por_mode", 32'(mode_q_o), 32'h0);
    rst_n = 1'b1;

    // Rotate left, then right.
    repeat (45) @(negedge clk);
    dir = 1'b1;
    repeat (45) @(negedge clk);

    // Count down from zero, then up.
    mode = 2'd3;
    repeat (35) @(negedge clk);
    dir = 1'b0;
    repeat (25) @(negedge clk);

    // Bounce with dir toggling mid-sequence.
    mode = 2'd2;
    for (int k = 0; k < 8; k++) begin
      repeat (13) @(negedge clk);
      dir = ~dir;
    end

    // Pause across a step boundary, then a mode change while paused.
    pause = 1'b1;
    repeat (25) @(negedge clk);
    pause = 1'b0;
    repeat (20) @(negedge clk);
    pause = 1'b1;
    mode = 2'd1;
    repeat (8) @(negedge clk);
    pause = 1'b0;
    repeat (30) @(negedge clk);

    // Reset pulsed mid-COUNT while showing 0110.
    mode = 2'd3;
    dir  = 1'b0;
    for (int k = 0; k < 200 && !(m_mode == 3 && cval == 6); k++) @(negedge clk);
    check("reach_0110", 32'(led), 32'h6);
    async_reset_pulse();
    mode = 2'd0;
    repeat (25) @(negedge clk);

    // Randomised switch activity.
    for (int it = 0; it < 250; it++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 3)      mode  = 2'($urandom_range(0, 3));
      else if (r < 6) dir   = ~dir;
      else if (r < 8) pause = ($urandom_range(0, 3) == 0);
      repeat ($urandom_range(1, 25)) @(negedge clk);
      if (it % 60 == 59) async_reset_pulse();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_pattern_engine.md
Name: led_pattern_engine

Overview:
- Parametrised LED pattern generator. It replaces the fixed 16-LED shift/flash pair and the 2:1 display mux with one engine.
- It has an internal step-rate divider, four run-time modes (rotate, flash, bounce, binary count), direction control and pause.
- It sits between the board clock/reset and the LED pins, and is driven directly by slide switches.

Parameters:
- LED_W, 16, number of LEDs driven; must be >= 2.
- CLK_HZ, 5000000, input clock frequency in Hz.
- STEP_HZ, 2, pattern step rate in Hz. DIV = CLK_HZ/STEP_HZ (integer division); must be >= 2.

Ports:
- CLK_5_MHZ  input  1  system clock; single clock domain.
- CPU_RESETN  input  1  asynchronous, active-low reset.
- mode  input  2  async switch input: 0 ROTATE, 1 FLASH, 2 BOUNCE, 3 COUNT.
- dir  input  1  async switch input: 0 = left/up, 1 = right/down.
- pause  input  1  async switch input: 1 freezes the pattern.
- led  output  LED_W  registered LED pattern.
- step_tick  output  1  one-cycle pulse on every pattern advance.
- mode_q  output  2  currently active (synchronised) mode.

Behaviour:
- Reset (CPU_RESETN=0, asynchronous): all registers clear at once.
  - Sync flops = 0, mode_q = 0 (ROTATE), led = 1 (bit 0 only), divider = 0, step_tick = 0, bounce direction = up.
- Synchronisation: mode, dir and pause each pass through a 2-flop synchroniser. All internal logic uses only the synchronised values.
- Divider: counter width clog2(DIV); counts 0..DIV-1 and wraps.
  - Internal tick is asserted when count == DIV-1 and pause_s == 0.
  - When pause_s == 1, the counter holds its value. step_tick is a registered copy of the tick, coincident with the led update.
- Mode change: when mode_s != mode_q, in that cycle:
  - mode_q <= mode_s, divider <= 0, bounce direction <= up.
  - led <= init(mode_s): ROTATE 1, FLASH 0, BOUNCE 1, COUNT 0.
  - Total latency: 3 clocks from switch edge to new led/mode_q.
- Priority, mode change over tick: a mode change in the same cycle as a tick takes priority. No pattern advance, and step_tick = 0 that cycle.
- Per tick, for each active mode:
  - ROTATE: dir_s=0 rotates left (MSB wraps to bit 0); dir_s=1 rotates right (bit 0 wraps to MSB).
  - FLASH: led <= ~led, so the pattern alternates between all-zeros and all-ones. dir_s is ignored.
  - BOUNCE: one-hot walk with ping-pong; dir_s is ignored.
    - Going up: if led[LED_W-1]=1, reverse and shift right; otherwise shift left.
    - Going down: mirror of the above at bit 0.
    - Sequence for LED_W=4: 0001,0010,0100,1000,0100,0010,0001,0010...
  - COUNT: dir_s=0 gives led+1, dir_s=1 gives led-1, modulo 2^LED_W (1111 -> 0000, 0000 -> 1111).
- dir change mid-mode: no reload. The next tick uses the new direction from the current led value.
- Pause: led, divider and bounce direction all freeze. Releasing pause resumes counting from the held divider value. A mode change while paused still reloads led and clears the divider.
- Reset mid-operation: immediate return to reset values. No step_tick is emitted until the first full DIV-cycle period after release.

Decomposition:
- Shared package/include led_pkg holds:
  - mode encodings MODE_ROTATE=2'd0, MODE_FLASH=2'd1, MODE_BOUNCE=2'd2, MODE_COUNT=2'd3;
  - direction constants DIR_UP=1'b0, DIR_DOWN=1'b1.
- One natural sub-module: sync_2ff, a parametrised-width 2-flop synchroniser with async active-low reset to 0, instantiated once for {mode, dir, pause}.
- Divider and pattern logic stay in led_pattern_engine.

Test Plan (bench parameters: LED_W=4, CLK_HZ=10, STEP_HZ=1, so DIV=10):
1. Reset release, mode=0, dir=0, pause=0 -> led=0001; led steps 0010,0100,1000,0001 at 10-clock spacing; step_tick is a single-cycle pulse with each step.
2. ROTATE with dir=1 from 0001 -> 1000,0100,0010,0001; MODE_COUNT with dir=1 from 0000 -> 1111,1110; dir=0 from 1111 -> 0000.
3. BOUNCE for 8 ticks -> exactly 0001,0010,0100,1000,0100,0010,0001,0010,0100; toggling dir mid-sequence changes nothing.
4. Switch mode 0->1 timed to land in the same cycle as a tick -> 3 clocks after the edge: led=0000, mode_q=1, no step_tick; next toggle to 1111 exactly 10 clocks later.
5. Pause asserted 4 clocks into a period for 25 clocks -> led and step_tick static; after release (plus 2-clock sync), next step arrives 6 clocks later.
6. CPU_RESETN pulsed low mid-COUNT with led=0110 -> led=0001, mode_q=0 and step_tick=0 immediately (asynchronous), before the next clock edge.
